// File: rtl/sram_1rw_512x32_arb_pkg.sv
`default_nettype none
// ============================================================================
// sram_1rw_512x32_arb_pkg : shared constants for the 1RW SRAM arbiter
// Rev 1.0
// ============================================================================
package sram_1rw_512x32_arb_pkg;

  localparam logic [0:0] c_ST_INIT     = 1'b0;
  localparam logic [0:0] c_ST_RUN      = 1'b1;

  localparam logic       c_RDWEN_READ  = 1'b1;
  localparam logic       c_RDWEN_WRITE = 1'b0;

  // rr_last starts at port 1 so port 0 wins the first conflict
  localparam logic       c_RR_LAST_RST = 1'b1;

  typedef logic [1:0] grant_t;

endpackage : sram_1rw_512x32_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_rr2.sv
`default_nettype none
// ============================================================================
// sram_arb_rr2 : two-way round-robin grant with last-winner register
// Rev 1.0
// ============================================================================
module sram_arb_rr2
  import sram_1rw_512x32_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  input  grant_t i_req,
  output grant_t o_grant
);

  logic   r_rr_last;
  grant_t w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_rr_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  // Only an actual grant moves the pointer, so idle cycles keep fairness state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last <= c_RR_LAST_RST;
    end else if (|w_grant) begin
      r_rr_last <= w_grant[1];
    end
  end

  assign o_grant = w_grant;

endmodule : sram_arb_rr2
`default_nettype wire

// File: rtl/sram_1rw_512x32_arb.sv
`default_nettype none
// ============================================================================
// sram_1rw_512x32_arb : shares one 1RW SRAM between two requesters, zero-fills after reset
// Rev 1.0
// ============================================================================
module sram_1rw_512x32_arb
  import sram_1rw_512x32_arb_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              MEMCLK,
  input  logic              RESET,

  input  logic              REQ0_VAL,
  output logic              REQ0_RDY,
  input  logic              REQ0_RDWEN,
  input  logic [ADDR_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ0_BW,
  input  logic [DATA_W-1:0] REQ0_DIN,
  output logic              RSP0_VAL,
  output logic [DATA_W-1:0] RSP0_DOUT,

  input  logic              REQ1_VAL,
  output logic              REQ1_RDY,
  input  logic              REQ1_RDWEN,
  input  logic [ADDR_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ1_BW,
  input  logic [DATA_W-1:0] REQ1_DIN,
  output logic              RSP1_VAL,
  output logic [DATA_W-1:0] RSP1_DOUT,

  output logic              SRAM_CE,
  output logic              SRAM_RDWEN,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_BW,
  output logic [DATA_W-1:0] SRAM_DIN,
  input  logic [DATA_W-1:0] SRAM_DOUT,

  output logic              INIT_DONE
);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic [1:0]        r_rsp_val;
  grant_t            w_grant;
  logic              w_arb_en;
  logic              w_init_last;

  assign w_init_last = (r_init_cnt == ADDR_W'(DEPTH - 1));

  // Arbitration is masked in the reset cycle so nothing granted then reaches the SRAM
  assign w_arb_en = (r_state == c_ST_RUN) && !RESET;

  sram_arb_rr2 u_rr2 (
    .clk     (MEMCLK),
    .rst     (RESET),
    .i_en    (w_arb_en),
    .i_req   ({REQ1_VAL, REQ0_VAL}),
    .o_grant (w_grant)
  );

  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      r_state <= INIT_EN ? c_ST_INIT : c_ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_INIT: if (w_init_last) w_state_nxt = c_ST_RUN;
      c_ST_RUN:  w_state_nxt = c_ST_RUN;
      default:   w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    SRAM_CE    = 1'b0;
    SRAM_RDWEN = c_RDWEN_READ;
    SRAM_A     = '0;
    SRAM_BW    = '0;
    SRAM_DIN   = '0;
    if (!RESET) begin
      case (r_state)
        c_ST_INIT: begin
          SRAM_CE    = 1'b1;
          SRAM_RDWEN = c_RDWEN_WRITE;
          SRAM_A     = r_init_cnt;
          SRAM_BW    = '1;
          SRAM_DIN   = '0;
        end
        c_ST_RUN: begin
          if (w_grant[0]) begin
            SRAM_CE    = 1'b1;
            SRAM_RDWEN = REQ0_RDWEN;
            SRAM_A     = REQ0_A;
            SRAM_BW    = REQ0_BW;
            SRAM_DIN   = REQ0_DIN;
          end else if (w_grant[1]) begin
            SRAM_CE    = 1'b1;
            SRAM_RDWEN = REQ1_RDWEN;
            SRAM_A     = REQ1_A;
            SRAM_BW    = REQ1_BW;
            SRAM_DIN   = REQ1_DIN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      r_init_cnt  <= '0;
      r_init_done <= ~INIT_EN;
    end else if (r_state == c_ST_INIT) begin
      r_init_cnt <= r_init_cnt + ADDR_W'(1);
      if (w_init_last) r_init_done <= 1'b1;
    end
  end

  // Read data comes straight from the SRAM one cycle later; only the valid is pipelined
  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      r_rsp_val <= 2'b00;
    end else begin
      r_rsp_val[0] <= w_grant[0] && (REQ0_RDWEN == c_RDWEN_READ);
      r_rsp_val[1] <= w_grant[1] && (REQ1_RDWEN == c_RDWEN_READ);
    end
  end

  assign REQ0_RDY  = w_grant[0];
  assign REQ1_RDY  = w_grant[1];
  assign RSP0_VAL  = r_rsp_val[0];
  assign RSP1_VAL  = r_rsp_val[1];
  assign RSP0_DOUT = SRAM_DOUT;
  assign RSP1_DOUT = SRAM_DOUT;
  assign INIT_DONE = r_init_done;

endmodule : sram_1rw_512x32_arb
`default_nettype wire

// File: tb/tb_sram_1rw_512x32_arb.sv
`default_nettype none
// ============================================================================
// tb_sram_1rw_512x32_arb : directed vectors with a response scoreboard
// Rev 1.0
// ============================================================================
module tb_sram_1rw_512x32_arb;

  localparam logic [31:0] c_FULL = 32'hFFFF_FFFF;
  localparam logic        c_RD   = 1'b1;
  localparam logic        c_WR   = 1'b0;

  logic        clk;
  logic        rst;
  logic        req0_val, req0_rdwen, req1_val, req1_rdwen;
  logic [8:0]  req0_a, req1_a;
  logic [31:0] req0_bw, req0_din, req1_bw, req1_din;
  logic        req0_rdy, req1_rdy, rsp0_val, rsp1_val;
  logic [31:0] rsp0_dout, rsp1_dout;
  logic        sram_ce, sram_rdwen;
  logic [8:0]  sram_a;
  logic [31:0] sram_bw, sram_din, sram_dout;
  logic        init_done;

  logic        ni_val0, ni_val1, ni_rdy0, ni_rdy1, ni_rsp0_val, ni_rsp1_val;
  logic [31:0] ni_rsp0_dout, ni_rsp1_dout, ni_bw, ni_din, ni_dout;
  logic        ni_ce, ni_rdwen, ni_init_done;
  logic [8:0]  ni_sram_a;
  logic [31:0] ni_sram_bw, ni_sram_din;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  sram_1rw_512x32_arb #(.DEPTH(512), .ADDR_W(9), .DATA_W(32), .INIT_EN(1'b1)) dut (
    .MEMCLK(clk), .RESET(rst),
    .REQ0_VAL(req0_val), .REQ0_RDY(req0_rdy), .REQ0_RDWEN(req0_rdwen), .REQ0_A(req0_a),
    .REQ0_BW(req0_bw), .REQ0_DIN(req0_din), .RSP0_VAL(rsp0_val), .RSP0_DOUT(rsp0_dout),
    .REQ1_VAL(req1_val), .REQ1_RDY(req1_rdy), .REQ1_RDWEN(req1_rdwen), .REQ1_A(req1_a),
    .REQ1_BW(req1_bw), .REQ1_DIN(req1_din), .RSP1_VAL(rsp1_val), .RSP1_DOUT(rsp1_dout),
    .SRAM_CE(sram_ce), .SRAM_RDWEN(sram_rdwen), .SRAM_A(sram_a), .SRAM_BW(sram_bw),
    .SRAM_DIN(sram_din), .SRAM_DOUT(sram_dout), .INIT_DONE(init_done)
  );

  sram_1rw_512x32_arb #(.DEPTH(512), .ADDR_W(9), .DATA_W(32), .INIT_EN(1'b0)) dut_ni (
    .MEMCLK(clk), .RESET(rst),
    .REQ0_VAL(ni_val0), .REQ0_RDY(ni_rdy0), .REQ0_RDWEN(c_RD), .REQ0_A(9'd0),
    .REQ0_BW(ni_bw), .REQ0_DIN(ni_din), .RSP0_VAL(ni_rsp0_val), .RSP0_DOUT(ni_rsp0_dout),
    .REQ1_VAL(ni_val1), .REQ1_RDY(ni_rdy1), .REQ1_RDWEN(c_RD), .REQ1_A(9'd0),
    .REQ1_BW(ni_bw), .REQ1_DIN(ni_din), .RSP1_VAL(ni_rsp1_val), .RSP1_DOUT(ni_rsp1_dout),
    .SRAM_CE(ni_ce), .SRAM_RDWEN(ni_rdwen), .SRAM_A(ni_sram_a), .SRAM_BW(ni_sram_bw),
    .SRAM_DIN(ni_sram_din), .SRAM_DOUT(ni_dout), .INIT_DONE(ni_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1RW SRAM, seeded with non-zero junk so the zero-fill is observable
  logic [31:0] mem [512];
  bit          seeded;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int k = 0; k < 512; k++) mem[k] <= 32'hA5A5_0000 | k;
      seeded <= 1'b1;
    end else if (sram_ce) begin
      if (sram_rdwen == 1'b0) mem[sram_a] <= (mem[sram_a] & ~sram_bw) | (sram_din & sram_bw);
      else                    sram_dout   <= mem[sram_a];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Response monitor: every RSPn_VAL must match the oldest expected read
  always @(negedge clk) begin
    if (rsp0_val === 1'b1) begin
      if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
      else                chk("rsp0_dout", rsp0_dout, q0.pop_front());
    end
    if (rsp1_val === 1'b1) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
      else                chk("rsp1_dout", rsp1_dout, q1.pop_front());
    end
  end

  task automatic apply(
    input logic v0, input logic rw0, input logic [8:0] a0, input logic [31:0] bw0, input logic [31:0] d0,
    input logic v1, input logic rw1, input logic [8:0] a1, input logic [31:0] bw1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic [31:0] e0, input logic [31:0] e1);
    req0_val = v0; req0_rdwen = rw0; req0_a = a0; req0_bw = bw0; req0_din = d0;
    req1_val = v1; req1_rdwen = rw1; req1_a = a1; req1_bw = bw1; req1_din = d1;
    @(negedge clk);
    chk("rdy0", req0_rdy, g0);
    chk("rdy1", req1_rdy, g1);
    chk("sram_ce", sram_ce, g0 | g1);
    if (g0 && rw0) q0.push_back(e0);
    if (g1 && rw1) q1.push_back(e1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_val = 0; req0_rdwen = c_RD; req0_a = '0; req0_bw = '0; req0_din = '0;
    req1_val = 0; req1_rdwen = c_RD; req1_a = '0; req1_bw = '0; req1_din = '0;
    ni_val0 = 1'b1; ni_val1 = 1'b0; ni_bw = '0; ni_din = '0; ni_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy0", req0_rdy, 0);
    chk("rst_rdy1", req1_rdy, 0);
    chk("rst_ce", sram_ce, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp0_val", rsp0_val, 0);
    chk("rst_ni_rdy0", ni_rdy0, 0);
    @(posedge clk); #1;

    // Zero-fill sweep with both clients requesting
    rst = 1'b0;
    req0_val = 1'b1; req1_val = 1'b1;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      n_vec++;
      if (!(req0_rdy === 1'b0 && req1_rdy === 1'b0 && sram_ce === 1'b1 && sram_rdwen === 1'b0 &&
            sram_a === i[8:0] && sram_bw === c_FULL && sram_din === 32'd0 && init_done === 1'b0)) begin
        n_err++;
        $display("FAIL init_sweep[%0d]: got rdy=%b%b ce=%b rdwen=%b a=%h bw=%h din=%h done=%b required a=%h",
                 i, req1_rdy, req0_rdy, sram_ce, sram_rdwen, sram_a, sram_bw, sram_din, init_done, i[8:0]);
      end
      if (i == 0) begin
        chk("ni_rdy0_first", ni_rdy0, 1);
        chk("ni_init_done", ni_init_done, 1);
      end
      @(posedge clk); #1;
    end
    req0_val = 1'b0; req1_val = 1'b0;
    @(negedge clk);
    chk("init_done_rise", init_done, 1);
    @(posedge clk); #1;

    //     p0: v  rw    addr    bw      din            p1: v  rw    addr    bw            din            g0 g1 exp0           exp1
    apply(1, c_WR, 9'h1FF, c_FULL, 32'hDEADBEEF, 0, c_RD, 9'h000, '0,           '0,            1, 0, '0,            '0);
    apply(1, c_RD, 9'h1FF, '0,     '0,           0, c_RD, 9'h000, '0,           '0,            1, 0, 32'hDEADBEEF, '0);
    apply(0, c_RD, 9'h000, '0,     '0,           1, c_RD, 9'h010, '0,           '0,            0, 1, '0,            32'h0);
    apply(0, c_RD, 9'h000, '0,     '0,           1, c_WR, 9'h021, 32'h0000FFFF, 32'hCAFEF00D,  0, 1, '0,            '0);
    apply(0, c_RD, 9'h000, '0,     '0,           1, c_WR, 9'h020, c_FULL,       32'h12345678,  0, 1, '0,            '0);
    apply(1, c_WR, 9'h005, c_FULL, 32'hA1B2C3D4, 0, c_RD, 9'h000, '0,           '0,            1, 0, '0,            '0);
    apply(1, c_RD, 9'h005, '0,     '0,           0, c_RD, 9'h000, '0,           '0,            1, 0, 32'hA1B2C3D4, '0);
    apply(0, c_RD, 9'h000, '0,     '0,           1, c_RD, 9'h020, '0,           '0,            0, 1, '0,            32'h12345678);
    // Continuous contention: grants alternate starting with port 0
    apply(1, c_RD, 9'h1FF, '0,     '0,           1, c_RD, 9'h021, '0,           '0,            1, 0, 32'hDEADBEEF, '0);
    apply(1, c_RD, 9'h005, '0,     '0,           1, c_RD, 9'h021, '0,           '0,            0, 1, '0,            32'h0000F00D);
    apply(1, c_RD, 9'h005, '0,     '0,           1, c_RD, 9'h020, '0,           '0,            1, 0, 32'hA1B2C3D4, '0);
    apply(1, c_RD, 9'h010, '0,     '0,           1, c_RD, 9'h020, '0,           '0,            0, 1, '0,            32'h12345678);
    apply(1, c_RD, 9'h010, '0,     '0,           1, c_RD, 9'h1FF, '0,           '0,            1, 0, 32'h0,         '0);
    apply(1, c_RD, 9'h020, '0,     '0,           1, c_RD, 9'h1FF, '0,           '0,            0, 1, '0,            32'hDEADBEEF);
    apply(1, c_RD, 9'h020, '0,     '0,           1, c_RD, 9'h005, '0,           '0,            1, 0, 32'h12345678, '0);
    apply(1, c_RD, 9'h021, '0,     '0,           1, c_RD, 9'h005, '0,           '0,            0, 1, '0,            32'hA1B2C3D4);
    apply(0, c_RD, 9'h000, '0,     '0,           0, c_RD, 9'h000, '0,           '0,            0, 0, '0,            '0);

    // Reset one cycle after a read grant: that response shows once, then is gone
    apply(1, c_RD, 9'h1FF, '0,     '0,           0, c_RD, 9'h000, '0,           '0,            1, 0, 32'hDEADBEEF, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_rdy0", req0_rdy, 0);
    chk("rst_cycle_ce", sram_ce, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp0_val", rsp0_val, 0);
    chk("post_rst_init_done", init_done, 0);
    chk("post_rst_rdy0", req0_rdy, 0);
    chk("restart_a0", {sram_ce, sram_rdwen, 30'd0} | 32'(sram_a), {1'b1, 1'b0, 30'd0});
    @(posedge clk); #1;
    req0_val = 1'b0;
    @(negedge clk);
    chk("restart_a1", 32'(sram_a), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sram_1rw_512x32_arb
`default_nettype wire
